// File: rtl/sdram_rr_arbiter.sv
// rtl/sdram_rr_arbiter.sv - two-port round-robin arbiter in front of the sdram controller user port
module sdram_rr_arbiter #(
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [3:0]        m0_sel,
    input  logic [ADDR_W-1:0] m0_adr,
    input  logic [DATA_W-1:0] m0_wdat,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdat,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [3:0]        m1_sel,
    input  logic [ADDR_W-1:0] m1_adr,
    input  logic [DATA_W-1:0] m1_wdat,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdat,
    output logic              m1_err,
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic              ctrl_rw,
    output logic [DATA_W-1:0] ctrl_wdata,
    output logic [3:0]        ctrl_mask,
    output logic              ctrl_in_valid,
    input  logic              ctrl_busy,
    input  logic [DATA_W-1:0] ctrl_rdata,
    input  logic              ctrl_out_valid
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, ACK} state_t;

    state_t             state, state_d;
    logic               grant, grant_d;
    logic               last_grant, last_grant_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [ADDR_W-1:0]  ctrl_addr_d;
    logic               ctrl_rw_d;
    logic [DATA_W-1:0]  ctrl_wdata_d;
    logic [3:0]         ctrl_mask_d;
    logic               ctrl_in_valid_d;
    logic               m0_ack_d, m1_ack_d, m0_err_d, m1_err_d;
    logic [DATA_W-1:0]  m0_rdat_d, m1_rdat_d;
    logic               pick, req_we;
    logic [3:0]         req_sel;
    logic               fin, fin_err;
    logic [DATA_W-1:0]  fin_data;

    always_comb begin
        state_d         = state;
        grant_d         = grant;
        last_grant_d    = last_grant;
        cnt_d           = cnt;
        ctrl_addr_d     = ctrl_addr;
        ctrl_rw_d       = ctrl_rw;
        ctrl_wdata_d    = ctrl_wdata;
        ctrl_mask_d     = ctrl_mask;
        ctrl_in_valid_d = 1'b0;
        pick            = 1'b0;
        req_we          = 1'b0;
        req_sel         = 4'h0;
        fin             = 1'b0;
        fin_err         = 1'b0;
        fin_data        = '0;
        m0_ack_d        = 1'b0;
        m1_ack_d        = 1'b0;
        m0_err_d        = 1'b0;
        m1_err_d        = 1'b0;
        m0_rdat_d       = '0;
        m1_rdat_d       = '0;

        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // on a tie the port that did not win last time goes first
                    pick            = (m0_req && m1_req) ? ~last_grant : m1_req;
                    req_we          = pick ? m1_we : m0_we;
                    req_sel         = pick ? m1_sel : m0_sel;
                    grant_d         = pick;
                    last_grant_d    = pick;
                    ctrl_addr_d     = pick ? m1_adr : m0_adr;
                    ctrl_wdata_d    = pick ? m1_wdat : m0_wdat;
                    ctrl_rw_d       = req_we;
                    ctrl_mask_d     = req_we ? req_sel : 4'h0;
                    ctrl_in_valid_d = 1'b1;
                    state_d         = req_we ? WR : RD_REQ;
                end
            end
            WR: begin
                if (ctrl_busy) begin
                    ctrl_in_valid_d = 1'b1;
                end else begin
                    fin     = 1'b1;
                    state_d = ACK;
                end
            end
            RD_REQ: begin
                if (ctrl_busy) begin
                    ctrl_in_valid_d = 1'b1;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                cnt_d = cnt + CNT_W'(1);
                // returned data beats a timeout landing in the same cycle
                if (ctrl_out_valid) begin
                    fin      = 1'b1;
                    fin_data = ctrl_rdata;
                    state_d  = ACK;
                end else if (TIMEOUT != 0 && cnt == TO_CNT) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (fin) begin
            m0_ack_d  = ~grant;
            m1_ack_d  = grant;
            m0_err_d  = ~grant & fin_err;
            m1_err_d  = grant & fin_err;
            m0_rdat_d = grant ? '0 : fin_data;
            m1_rdat_d = grant ? fin_data : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            cnt           <= '0;
            ctrl_addr     <= '0;
            ctrl_rw       <= 1'b0;
            ctrl_wdata    <= '0;
            ctrl_mask     <= 4'h0;
            ctrl_in_valid <= 1'b0;
            m0_ack        <= 1'b0;
            m1_ack        <= 1'b0;
            m0_err        <= 1'b0;
            m1_err        <= 1'b0;
            m0_rdat       <= '0;
            m1_rdat       <= '0;
        end else begin
            state         <= state_d;
            grant         <= grant_d;
            last_grant    <= last_grant_d;
            cnt           <= cnt_d;
            ctrl_addr     <= ctrl_addr_d;
            ctrl_rw       <= ctrl_rw_d;
            ctrl_wdata    <= ctrl_wdata_d;
            ctrl_mask     <= ctrl_mask_d;
            ctrl_in_valid <= ctrl_in_valid_d;
            m0_ack        <= m0_ack_d;
            m1_ack        <= m1_ack_d;
            m0_err        <= m0_err_d;
            m1_err        <= m1_err_d;
            m0_rdat       <= m0_rdat_d;
            m1_rdat       <= m1_rdat_d;
        end
    end

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// tb/tb_sdram_rr_arbiter.sv - scoreboard bench for sdram_rr_arbiter with a behavioural controller
module tb_sdram_rr_arbiter;

    localparam int AW = 25;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [3:0]    m0_sel, m1_sel;
    logic [AW-1:0] m0_adr, m1_adr;
    logic [DW-1:0] m0_wdat, m1_wdat;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic [DW-1:0] m0_rdat, m1_rdat;
    logic [AW-1:0] ctrl_addr;
    logic          ctrl_rw, ctrl_in_valid, ctrl_busy, ctrl_out_valid;
    logic [DW-1:0] ctrl_wdata, ctrl_rdata;
    logic [3:0]    ctrl_mask;

    always #5 clk = ~clk;

    sdram_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_adr(m0_adr), .m0_wdat(m0_wdat),
        .m0_ack(m0_ack), .m0_rdat(m0_rdat), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_adr(m1_adr), .m1_wdat(m1_wdat),
        .m1_ack(m1_ack), .m1_rdat(m1_rdat), .m1_err(m1_err),
        .ctrl_addr(ctrl_addr), .ctrl_rw(ctrl_rw), .ctrl_wdata(ctrl_wdata), .ctrl_mask(ctrl_mask),
        .ctrl_in_valid(ctrl_in_valid), .ctrl_busy(ctrl_busy), .ctrl_rdata(ctrl_rdata),
        .ctrl_out_valid(ctrl_out_valid)
    );

    // kind: 0 write, 1 read with data, 2 read timeout
    typedef struct { int port; int kind; logic [31:0] rdat; int exp_cyc; } ack_t;
    typedef struct { logic [AW-1:0] addr; bit rw; logic [31:0] wdata; logic [3:0] mask; } cmd_t;

    ack_t        exp_ack[$];
    cmd_t        exp_cmd[$];
    logic [31:0] ref_mem[int];
    logic [31:0] dev_mem[int];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          model_last = 1'b1;
    int          busy_cfg = 0, rd_delay = 1, busy_left = 0, rd_due = -1, acc_cyc = 0, ov_cyc = 0;
    bit          drop_rd = 1'b0, cmd_active = 1'b0, prev_accept = 1'b0;
    logic [31:0] rd_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (sel[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
    endfunction

    function automatic logic [31:0] dev_rd(input logic [AW-1:0] a);
        return dev_mem.exists(int'(a)) ? dev_mem[int'(a)] : 32'h0;
    endfunction

    // behavioural controller: programmable busy stretch, read latency, dropped reads
    initial begin
        ctrl_busy = 1'b0; ctrl_out_valid = 1'b0; ctrl_rdata = '0;
        forever begin
            @(negedge clk);
            ctrl_out_valid = 1'b0;
            ctrl_rdata     = '0;
            if (rd_due == cyc) begin
                ctrl_out_valid = 1'b1;
                ctrl_rdata     = rd_data;
                ov_cyc         = cyc;
                rd_due         = -1;
            end
            if (prev_accept) begin
                chk("in_valid_drop", ctrl_in_valid, 0);
                prev_accept = 1'b0;
            end
            ctrl_busy = 1'b0;
            if (ctrl_in_valid && rst_n) begin
                if (exp_cmd.size() == 0) begin
                    chk("cmd_unexpected", 1, 0);
                end else begin
                    chk("cmd_addr", ctrl_addr, exp_cmd[0].addr);
                    chk("cmd_rw", ctrl_rw, exp_cmd[0].rw);
                    chk("cmd_mask", ctrl_mask, exp_cmd[0].mask);
                    if (exp_cmd[0].rw) chk("cmd_wdata", ctrl_wdata, exp_cmd[0].wdata);
                end
                if (!cmd_active) begin
                    cmd_active = 1'b1;
                    busy_left  = busy_cfg;
                end
                if (busy_left > 0) begin
                    ctrl_busy = 1'b1;
                    busy_left--;
                end else begin
                    cmd_active  = 1'b0;
                    prev_accept = 1'b1;
                    acc_cyc     = cyc;
                    if (exp_cmd.size() != 0) void'(exp_cmd.pop_front());
                    if (ctrl_rw) begin
                        dev_mem[int'(ctrl_addr)] = merge(dev_rd(ctrl_addr), ctrl_wdata, ctrl_mask);
                    end else if (!drop_rd) begin
                        rd_due  = cyc + rd_delay;
                        rd_data = dev_rd(ctrl_addr);
                    end
                end
            end
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && (m0_ack || m1_ack)) begin
            ack_t e;
            int   p;
            int   want;
            chk("single_ack", {m0_ack, m1_ack} == 2'b11, 0);
            if (exp_ack.size() == 0) begin
                chk("ack_unexpected", 1, 0);
            end else begin
                e = exp_ack.pop_front();
                p = m1_ack ? 1 : 0;
                chk("ack_port", p, e.port);
                chk("ack_err", p ? m1_err : m0_err, e.kind == 2);
                if (e.kind != 0) chk("ack_rdat", p ? m1_rdat : m0_rdat, e.rdat);
                want = (e.kind == 0) ? acc_cyc + 1 : (e.kind == 1) ? ov_cyc + 1 : acc_cyc + TO + 2;
                chk("ack_cycle", cyc, want);
                if (e.exp_cyc >= 0) chk("req_to_ack", cyc, e.exp_cyc);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_m0_ack"}, m0_ack, 0);
        chk({tag, "_m1_ack"}, m1_ack, 0);
        chk({tag, "_m0_err"}, m0_err, 0);
        chk({tag, "_m1_err"}, m1_err, 0);
        chk({tag, "_m0_rdat"}, m0_rdat, 0);
        chk({tag, "_m1_rdat"}, m1_rdat, 0);
        chk({tag, "_in_valid"}, ctrl_in_valid, 0);
        chk({tag, "_rw"}, ctrl_rw, 0);
        chk({tag, "_addr"}, ctrl_addr, 0);
        chk({tag, "_wdata"}, ctrl_wdata, 0);
        chk({tag, "_mask"}, ctrl_mask, 0);
    endtask

    task automatic run_round(input bit r0, input bit r1, input bit we0, input bit we1,
                             input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic [3:0] s0, input logic [3:0] s1,
                             input int busy, input int rdd, input bit drop);
        int          order[$];
        bit          we_a[2];
        logic [AW-1:0] a_a[2];
        logic [31:0] d_a[2];
        logic [3:0]  s_a[2];
        bit          got0, got1;
        int          n;
        we_a[0] = we0; we_a[1] = we1; a_a[0] = a0; a_a[1] = a1;
        d_a[0] = d0; d_a[1] = d1; s_a[0] = s0; s_a[1] = s1;
        @(negedge clk);
        busy_cfg = busy; rd_delay = rdd; drop_rd = drop;
        if (r0 && r1) begin
            order.push_back(model_last ? 0 : 1);
            order.push_back(model_last ? 1 : 0);
        end else begin
            order.push_back(r1 ? 1 : 0);
        end
        model_last = order[order.size() - 1][0];
        foreach (order[i]) begin
            int   p;
            cmd_t c;
            ack_t e;
            p = order[i];
            c.addr = a_a[p]; c.rw = we_a[p]; c.wdata = d_a[p]; c.mask = we_a[p] ? s_a[p] : 4'h0;
            exp_cmd.push_back(c);
            e.port = p;
            e.exp_cyc = (order.size() == 1 && we_a[p] && busy == 0) ? cyc + 2 : -1;
            if (we_a[p]) begin
                ref_mem[int'(a_a[p])] = merge(ref_rd(a_a[p]), d_a[p], s_a[p]);
                e.kind = 0; e.rdat = '0;
            end else if (drop) begin
                e.kind = 2; e.rdat = '0;
            end else begin
                e.kind = 1; e.rdat = ref_rd(a_a[p]);
            end
            exp_ack.push_back(e);
        end
        m0_req = r0; m0_we = we0; m0_adr = a0; m0_wdat = d0; m0_sel = s0;
        m1_req = r1; m1_we = we1; m1_adr = a1; m1_wdat = d1; m1_sel = s1;
        got0 = !r0; got1 = !r1; n = 0;
        while (!(got0 && got1) && n < 300) begin
            @(negedge clk);
            n++;
            if (m0_ack && !got0) begin got0 = 1'b1; m0_req = 1'b0; end
            if (m1_ack && !got1) begin got1 = 1'b1; m1_req = 1'b0; end
        end
        if (!(got0 && got1)) begin
            chk("ack_wait_bound", {got0, got1}, 2'b11);
            m0_req = 1'b0; m1_req = 1'b0;
            exp_ack.delete(); exp_cmd.delete();
        end
    endtask

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 3))
            0: return AW'(32'h100);
            1: return AW'(32'h104);
            2: return AW'(32'h1FF_FFFC);
            default: return AW'($urandom);
        endcase
    endfunction

    task automatic rand_round();
        int sel_ports;
        bit r0, r1, drop;
        sel_ports = $urandom_range(0, 2);
        r0 = (sel_ports != 1);
        r1 = (sel_ports != 0);
        drop = ($urandom_range(0, 7) == 0);
        run_round(r0, r1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  pick_addr(), pick_addr(), $urandom, $urandom,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(1, 8), drop);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_bound: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1);
    end

    initial begin
        int n0;
        m0_req = 0; m0_we = 0; m0_sel = 0; m0_adr = 0; m0_wdat = 0;
        m1_req = 0; m1_we = 0; m1_sel = 0; m1_adr = 0; m1_wdat = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        run_round(1, 0, 1, 0, 25'h100, 25'h0, 32'hA5A5_0001, 32'h0, 4'hF, 4'h0, 0, 5, 0);
        run_round(0, 1, 0, 0, 25'h0, 25'h100, 32'h0, 32'h0, 4'h0, 4'h0, 0, 5, 0);
        for (int i = 0; i < 3; i++)
            run_round(1, 1, 1, 1, AW'(32'h200 + 8 * i), AW'(32'h204 + 8 * i),
                      32'h1000_0000 + i, 32'h2000_0000 + i, 4'hF, 4'h3, 0, 1, 0);
        run_round(1, 0, 1, 0, 25'h300, 25'h0, 32'hDEAD_BEEF, 32'h0, 4'h5, 4'h0, 8, 1, 0);
        run_round(0, 1, 0, 0, 25'h0, 25'h100, 32'h0, 32'h0, 4'h0, 4'h0, 0, 5, 1);
        run_round(1, 0, 0, 0, 25'h300, 25'h0, 32'h0, 32'h0, 4'h0, 4'h0, 0, 3, 0);
        run_round(1, 0, 0, 0, 25'h200, 25'h0, 32'h0, 32'h0, 4'h0, 4'h0, 0, TO + 1, 0);
        run_round(0, 1, 0, 0, 25'h0, 25'h204, 32'h0, 32'h0, 4'h0, 4'h0, 0, TO, 0);

        // reset while the granted read sits in RD_WAIT; its data arrives after reset
        @(negedge clk);
        busy_cfg = 0; rd_delay = 10; drop_rd = 0;
        begin
            cmd_t c;
            c.addr = 25'h100; c.rw = 1'b0; c.wdata = 32'h0; c.mask = 4'h0;
            exp_cmd.push_back(c);
        end
        m0_req = 1; m0_we = 0; m0_adr = 25'h100; m0_wdat = 0; m0_sel = 0;
        n0 = cyc;
        repeat (4) @(negedge clk);
        rst_n = 1'b0; m0_req = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset");
        rst_n = 1'b1;
        model_last = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("post_reset_in_valid", ctrl_in_valid, 0);
        end
        chk("late_out_valid_seen", ov_cyc, n0 + 11);
        run_round(1, 1, 1, 0, 25'h400, 25'h100, 32'h0BAD_F00D, 32'h0, 4'hF, 4'h0, 0, 2, 0);

        for (int i = 0; i < 40; i++) rand_round();

        repeat (5) @(negedge clk);
        chk("ack_queue_empty", exp_ack.size(), 0);
        chk("cmd_queue_empty", exp_cmd.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
